// File: rtl/gpio_pad_config_sequencer_if.sv
// Register port, start/busy/done handshake and serial chain pins
// of the pad configuration sequencer.
interface gpio_pad_config_sequencer_if #(
  parameter int ADDR_W   = 6,
  parameter int CFG_BITS = 13
);
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [CFG_BITS-1:0] cfg_wdata;
  logic [CFG_BITS-1:0] cfg_rdata;
  logic                cfg_wr_err;
  logic                start;
  logic                busy;
  logic                done;
  logic                serial_clock;
  logic                serial_data;
  logic                serial_load;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    output start,
    input  cfg_rdata,
    input  cfg_wr_err,
    input  busy,
    input  done,
    input  serial_clock,
    input  serial_data,
    input  serial_load
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    input  start,
    output cfg_rdata,
    output cfg_wr_err,
    output busy,
    output done,
    output serial_clock,
    output serial_data,
    output serial_load
  );
endinterface

// File: rtl/gpio_pad_config_sequencer.sv
// Per-pad configuration store that shifts every word into the
// mprj_io pad-control chain, last pad and MSB first.
module gpio_pad_config_sequencer #(
  parameter int NUM_IO   = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4,
  parameter int ADDR_W   = 6,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG =
    CFG_BITS'(13'h0403)
) (
  input logic clock,
  input logic reset,
  gpio_pad_config_sequencer_if.slave bus
);

  localparam int BIT_W = $clog2(CFG_BITS);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [CFG_BITS-1:0] store_q [NUM_IO];
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [ADDR_W-1:0]   pad_q, pad_n;
  logic [DIV_W-1:0]    div_q;
  logic                sdata_q;
  logic [CFG_BITS-1:0] rdata_q;
  logic                wr_err_q;

  logic                busy;
  logic                in_range;
  logic                wr_ok;
  logic                div_end;
  logic                last_bit;
  logic                advance;
  logic [CFG_BITS-1:0] rd_word;
  logic [CFG_BITS-1:0] nxt_word;

  assign busy = (state_q == SHIFT_LO) ||
                (state_q == SHIFT_HI) ||
                (state_q == LOAD);

  assign in_range = {1'b0, bus.cfg_addr} <
                    (ADDR_W+1)'(NUM_IO);
  assign wr_ok    = bus.cfg_we && in_range && !busy;
  assign div_end  = div_q == DIV_W'(CLK_DIV - 1);
  assign last_bit = (pad_q == '0) && (bit_q == '0);

  assign advance =
    (state_d == SHIFT_LO) &&
    ((state_q == IDLE) || (state_q == SHIFT_HI));

  always_comb begin
    bit_n = bit_q - BIT_W'(1);
    pad_n = pad_q;
    if (state_q == IDLE) begin
      bit_n = BIT_W'(CFG_BITS - 1);
      pad_n = ADDR_W'(NUM_IO - 1);
    end else if (bit_q == '0) begin
      bit_n = BIT_W'(CFG_BITS - 1);
      pad_n = pad_q - ADDR_W'(1);
    end
  end

  // Writes are locked out while busy, so the live store doubles
  // as the start-time snapshot of every pad word.
  always_comb begin
    rd_word  = '0;
    nxt_word = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (bus.cfg_addr == ADDR_W'(i))
        rd_word = store_q[i];
      if (pad_n == ADDR_W'(i))
        nxt_word = store_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.start) state_d = SHIFT_LO;
      SHIFT_LO: if (div_end) state_d = SHIFT_HI;
      SHIFT_HI: if (div_end)
                  state_d = last_bit ? LOAD : SHIFT_LO;
      LOAD:     if (div_end) state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      pad_q    <= '0;
      div_q    <= '0;
      sdata_q  <= 1'b0;
      rdata_q  <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < NUM_IO; i++)
        store_q[i] <= DEFAULT_CFG;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rd_word;
      wr_err_q <= bus.cfg_we && !wr_ok;
      for (int i = 0; i < NUM_IO; i++)
        if (wr_ok && bus.cfg_addr == ADDR_W'(i))
          store_q[i] <= bus.cfg_wdata;
      if (!busy || state_d != state_q)
        div_q <= '0;
      else
        div_q <= div_q + DIV_W'(1);
      if (advance) begin
        bit_q   <= bit_n;
        pad_q   <= pad_n;
        sdata_q <= nxt_word[bit_n];
      end else if (state_d != SHIFT_LO &&
                   state_d != SHIFT_HI) begin
        sdata_q <= 1'b0;
      end
    end
  end

  assign bus.cfg_rdata    = rdata_q;
  assign bus.cfg_wr_err   = wr_err_q;
  assign bus.busy         = busy;
  assign bus.done         = state_q == FIN;
  assign bus.serial_clock = state_q == SHIFT_HI;
  assign bus.serial_data  = sdata_q;
  assign bus.serial_load  = state_q == LOAD;

endmodule

// File: tb/tb_gpio_pad_config_sequencer.sv
// Directed bench: two pads, one instance with CLK_DIV=1 and one
// with CLK_DIV=3, checked against hand-computed values.
module tb_gpio_pad_config_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  addr;
  logic [12:0] wdata;
  logic        start;
  logic [1:0]  en;
  logic        mon;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  gpio_pad_config_sequencer_if #(.ADDR_W(3), .CFG_BITS(13)) b0();
  gpio_pad_config_sequencer_if #(.ADDR_W(3), .CFG_BITS(13)) b1();

  assign b0.cfg_we    = we & en[0];
  assign b0.cfg_addr  = addr;
  assign b0.cfg_wdata = wdata;
  assign b0.start     = start & en[0];
  assign b1.cfg_we    = we & en[1];
  assign b1.cfg_addr  = addr;
  assign b1.cfg_wdata = wdata;
  assign b1.start     = start & en[1];

  gpio_pad_config_sequencer #(
    .NUM_IO(2), .CFG_BITS(13), .CLK_DIV(1),
    .ADDR_W(3), .DEFAULT_CFG(13'h0403)
  ) u0 (.clock(clock), .reset(reset), .bus(b0));

  gpio_pad_config_sequencer #(
    .NUM_IO(2), .CFG_BITS(13), .CLK_DIV(3),
    .ADDR_W(3), .DEFAULT_CFG(13'h0403)
  ) u1 (.clock(clock), .reset(reset), .bus(b1));

  wire        m_busy  = mon ? b1.busy : b0.busy;
  wire        m_done  = mon ? b1.done : b0.done;
  wire        m_sclk  = mon ? b1.serial_clock : b0.serial_clock;
  wire        m_sdata = mon ? b1.serial_data : b0.serial_data;
  wire        m_load  = mon ? b1.serial_load : b0.serial_load;
  wire        m_err   = mon ? b1.cfg_wr_err : b0.cfg_wr_err;
  wire [12:0] m_rdata = mon ? b1.cfg_rdata : b0.cfg_rdata;

  int          r_busy, r_load, r_done, r_err, r_nbits;
  int          hi_min, hi_max, lo_min, lo_max;
  bit          r_timeout, r_unstable;
  logic        r_rst_busy, r_rst_sclk;
  logic [63:0] r_bits;
  logic [25:0] exp_stream;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // kind: 0 none, 1 write addr 0, 2 extra start, 3 reset
  task automatic run_shift(input int kind, input int inj,
                           input int max_cyc);
    int   cyc = 0;
    int   idle_n = 0;
    int   hi_run = 0;
    int   lo_run = 0;
    logic ps = 1'b0;
    logic psd = 1'b0;
    r_busy = 0; r_load = 0; r_done = 0; r_err = 0;
    r_nbits = 0; r_bits = '0; r_unstable = 1'b0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    r_rst_busy = 1'bx; r_rst_sclk = 1'bx;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < max_cyc && idle_n < 5) begin
      if (m_busy) r_busy++; else idle_n++;
      if (m_load) r_load++;
      if (m_done) r_done++;
      if (m_err)  r_err++;
      if (m_sclk && m_sdata !== psd) r_unstable = 1'b1;
      if (m_sclk && !ps) begin
        r_bits = {r_bits[62:0], m_sdata};
        r_nbits++;
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
        lo_run = 0;
      end
      if (m_sclk) begin
        hi_run++;
      end else if (ps) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      if (m_busy && !m_sclk && !m_load) lo_run++;
      if (cyc == inj + 1) begin
        r_rst_busy = m_busy;
        r_rst_sclk = m_sclk;
        we = 1'b0; start = 1'b0; reset = 1'b0;
      end
      if (cyc == inj) begin
        case (kind)
          1: begin we = 1'b1; addr = 3'd0; wdata = 13'h1fff; end
          2: start = 1'b1;
          3: reset = 1'b1;
          default: ;
        endcase
      end
      ps  = m_sclk;
      psd = m_sdata;
      tick();
      cyc++;
    end
    r_timeout = idle_n < 5;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; start = 1'b0;
    addr = 3'd0; wdata = '0; en = 2'b11; mon = 1'b0;
    exp_stream = {13'h1803, 13'h0403};
    repeat (3) tick();
    chk("rst_busy",  m_busy,  0);
    chk("rst_done",  m_done,  0);
    chk("rst_sclk",  m_sclk,  0);
    chk("rst_sdata", m_sdata, 0);
    chk("rst_load",  m_load,  0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_err",   m_err,   0);
    reset = 1'b0;
    addr = 3'd0; tick();
    chk("rd_def0", m_rdata, 13'h0403);
    addr = 3'd1; tick();
    chk("rd_def1", m_rdata, 13'h0403);

    we = 1'b1; addr = 3'd5; wdata = 13'h1555; tick();
    we = 1'b0;
    chk("oor_err",  m_err,   1);
    chk("oor_rd",   m_rdata, 0);
    tick();
    chk("oor_err_off", m_err, 0);
    chk("oor_rd2",  m_rdata, 0);

    we = 1'b1; addr = 3'd0; wdata = 13'h0aaa; tick();
    we = 1'b0;
    chk("rd_old", m_rdata, 13'h0403);
    tick();
    chk("rd_new", m_rdata, 13'h0aaa);
    we = 1'b1; addr = 3'd0; wdata = 13'h0403; tick();
    addr = 3'd1; wdata = 13'h1803; tick();
    we = 1'b0; tick();
    chk("rd_p1",  m_rdata, 13'h1803);
    chk("wr_err_ok", m_err, 0);

    en = 2'b01; mon = 1'b0;
    run_shift(0, -10, 200);
    chk("sh_tmo",   r_timeout, 0);
    chk("sh_busy",  r_busy, 53);
    chk("sh_nbits", r_nbits, 26);
    chk("sh_data",  r_bits[25:0], exp_stream);
    chk("sh_load",  r_load, 1);
    chk("sh_done",  r_done, 1);
    chk("sh_err",   r_err, 0);

    run_shift(1, 10, 200);
    chk("bw_tmo",  r_timeout, 0);
    chk("bw_err",  r_err, 1);
    chk("bw_data", r_bits[25:0], exp_stream);
    chk("bw_busy", r_busy, 53);
    addr = 3'd0; tick(); tick();
    chk("bw_rd0", m_rdata, 13'h0403);

    run_shift(2, 20, 200);
    chk("sb_tmo",  r_timeout, 0);
    chk("sb_done", r_done, 1);
    chk("sb_busy", r_busy, 53);
    chk("sb_data", r_bits[25:0], exp_stream);

    en = 2'b10; mon = 1'b1;
    run_shift(0, -10, 500);
    chk("dv_tmo",    r_timeout, 0);
    chk("dv_busy",   r_busy, 159);
    chk("dv_hi_min", hi_min, 3);
    chk("dv_hi_max", hi_max, 3);
    chk("dv_lo_min", lo_min, 3);
    chk("dv_lo_max", lo_max, 3);
    chk("dv_stable", r_unstable, 0);
    chk("dv_data",   r_bits[25:0], exp_stream);
    chk("dv_load",   r_load, 3);
    chk("dv_done",   r_done, 1);

    en = 2'b01; mon = 1'b0;
    run_shift(3, 20, 200);
    chk("rs_tmo",   r_timeout, 0);
    chk("rs_nbits", r_nbits, 10);
    chk("rs_busy",  r_busy, 21);
    chk("rs_pbusy", r_rst_busy, 0);
    chk("rs_psclk", r_rst_sclk, 0);
    chk("rs_load",  r_load, 0);
    chk("rs_done",  r_done, 0);
    addr = 3'd1; tick(); tick();
    chk("rs_rd1", m_rdata, 13'h0403);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
